// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings plus a width-generic two's-complement negate helper.
package mdu_pkg;

    // Widest value the negate helper handles; covers a 2*WIDTH product for WIDTH <= 64.
    localparam int MDU_MAX_W = 128;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SIGN = 2'd2
    } mdu_state_e;

    // Conditional two's-complement negate; callers zero-extend in and truncate out,
    // so the same helper serves operand magnitudes and the double-width product.
    function automatic logic [MDU_MAX_W-1:0] mdu_cond_neg(input logic [MDU_MAX_W-1:0] v,
                                                          input logic                 neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: MSB-first shift-add, acc = 2*acc + (multiplier bit ? multiplicand : 0).
// Divide: restoring shift-subtract on acc = {remainder, dividend/quotient}; the
// dividend shifts out of the low half while quotient bits shift in behind it.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               i_is_div,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic               i_mbit,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [2*WIDTH-1:0] w_mul;
    logic [WIDTH:0]     w_shrem;
    logic [WIDTH:0]     w_diff;

    // Single add-or-subtract slice; the borrow bit of w_diff decides the quotient bit.
    always_comb begin
        w_mul   = {i_acc[2*WIDTH-2:0], 1'b0} + (i_mbit ? {{WIDTH{1'b0}}, i_opnd} : '0);
        w_shrem = i_acc[2*WIDTH-1:WIDTH-1];
        w_diff  = w_shrem - {1'b0, i_opnd};
        if (i_is_div) begin
            if (!w_diff[WIDTH]) begin
                o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {w_shrem[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc = w_mul;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// FSM IDLE -> RUN (one bit per cycle) -> SIGN (fix signs, write HI/LO) -> IDLE.
// Optional build macro MDU_EARLY_OUT_EN: multiplies only iterate over the
// significant bits of |b| (at least one); divides always take WIDTH steps.
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int W2    = 2 * WIDTH;

    mdu_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic             r_done;

    logic [W2-1:0]    r_acc;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_opnd;
    logic             r_is_div, r_neg_q, r_neg_r, r_dz;

    logic             w_accept, w_write;
    logic             w_signed, w_is_div, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_x_init;
    logic [CNT_W-1:0] w_n;
    logic [W2-1:0]    w_step_acc, w_prod;
    logic [WIDTH-1:0] w_quo, w_rem, w_res_hi, w_res_lo;

    // Operand decode at accept: signed ops work on magnitudes and remember the signs.
    assign w_is_div = op[1];
    assign w_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_mag  = WIDTH'(mdu_cond_neg(MDU_MAX_W'(a), w_a_neg));
    assign w_b_mag  = WIDTH'(mdu_cond_neg(MDU_MAX_W'(b), w_b_neg));

`ifdef MDU_EARLY_OUT_EN
    function automatic logic [CNT_W-1:0] bit_len(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) n = CNT_W'(i + 1);
        end
        return n;
    endfunction

    assign w_n = w_is_div                  ? CNT_W'(WIDTH) :
                 (bit_len(w_b_mag) == '0)  ? CNT_W'(1)     : bit_len(w_b_mag);
`else
    assign w_n = CNT_W'(WIDTH);
`endif

    // Left-align the multiplier so its top significant bit is consumed first.
    assign w_x_init = w_b_mag << (CNT_W'(WIDTH) - w_n);

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_mbit   (r_x[WIDTH-1]),
        .i_opnd   (r_opnd),
        .o_acc    (w_step_acc)
    );

    // Sign fix-up applied in SIGN. Divide-by-zero leaves |a| as remainder, which the
    // dividend-sign rule turns back into a; only the quotient needs forcing.
    assign w_prod   = W2'(mdu_cond_neg(MDU_MAX_W'(r_acc), r_neg_q));
    assign w_quo    = WIDTH'(mdu_cond_neg(MDU_MAX_W'(r_acc[WIDTH-1:0]), r_neg_q));
    assign w_rem    = WIDTH'(mdu_cond_neg(MDU_MAX_W'(r_acc[W2-1:WIDTH]), r_neg_r));
    assign w_res_hi = r_is_div ? w_rem : w_prod[W2-1:WIDTH];
    assign w_res_lo = r_is_div ? (r_dz ? '1 : w_quo) : w_prod[WIDTH-1:0];

    // Next-state logic: flush beats start in IDLE and squashes RUN/SIGN without a write.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !flush) begin
                    w_state_nxt = ST_RUN;
                    w_accept    = 1'b1;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_SIGN;
                end
            end
            ST_SIGN: begin
                w_state_nxt = ST_IDLE;
                w_write     = !flush;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Iteration counter, done pulse and the architectural HI/LO registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= w_write;
            if (w_accept) begin
                r_cnt <= w_n;
            end else if (w_state_nxt == ST_RUN) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_write) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (r_state == ST_IDLE) begin
                if (hi_we) r_hi <= wd;
                if (lo_we) r_lo <= wd;
            end
        end
    end

    // Datapath registers: loaded at accept, advanced one step per RUN cycle.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_div <= w_is_div;
            r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
            r_x      <= w_x_init;
            r_acc    <= w_is_div ? {{WIDTH{1'b0}}, w_a_mag} : '0;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= (b == '0);
        end else if (r_state == ST_RUN) begin
            r_acc <= w_step_acc;
            r_x   <= r_x << 1;
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32) with hand-computed expectations.
module tb_muldiv_unit;

`ifdef MDU_EARLY_OUT_EN
    localparam int LAT_3X5 = 4;
    localparam int LAT_X0  = 2;
`else
    localparam int LAT_3X5 = 33;
    localparam int LAT_X0  = 33;
`endif

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        start   = 1'b0;
    logic [1:0]  op      = 2'b00;
    logic [31:0] a       = '0;
    logic [31:0] b       = '0;
    logic        flush   = 1'b0;
    logic        hi_we   = 1'b0;
    logic        lo_we   = 1'b0;
    logic [31:0] wd      = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_chk = 0;
    int n_bad = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wd      (wd),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges after the accept edge until done is seen; 200 means it never came.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, bc, ndone;

        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(negedge clk);
        reset_n = 1'b1;

        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        check("multu_max_lat", lat, 33);
        check("multu_max_busy", bc, 33);
        check("multu_max_done", done, 1);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);

        // Launched in the done cycle of the previous op.
        launch(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, bc);
        check("mult_neg_lat", lat, 33);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFEB);
        @(posedge clk);
        #1;
        check("done_pulse_len", done, 0);

        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bc);
        check("div_neg_lat", lat, 33);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);

        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);

        launch(2'b11, 32'd7, 32'd0);
        wait_done(lat, bc);
        check("divu_z_lo", lo, 32'hFFFF_FFFF);
        check("divu_z_hi", hi, 32'd7);

        launch(2'b10, 32'hFFFF_FFF9, 32'd0);
        wait_done(lat, bc);
        check("div_z_lo", lo, 32'hFFFF_FFFF);
        check("div_z_hi", hi, 32'hFFFF_FFF9);

        launch(2'b01, 32'd3, 32'd5);
        wait_done(lat, bc);
        check("multu_3x5_lat", lat, LAT_3X5);
        check("multu_3x5_lo", lo, 32'd15);

        launch(2'b01, 32'h1234_5678, 32'd0);
        wait_done(lat, bc);
        check("multu_x0_lat", lat, LAT_X0);
        check("multu_x0_lo", lo, 32'd0);
        check("multu_x0_hi", hi, 32'd0);

        // Prior HI/LO before the squashed divide.
        launch(2'b10, 32'hFFFF_FFF9, 32'd0);
        wait_done(lat, bc);
        launch(2'b11, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("flush_no_done", ndone, 0);
        check("flush_hi_kept", hi, 32'hFFFF_FFF9);
        check("flush_lo_kept", lo, 32'hFFFF_FFFF);

        launch(2'b01, 32'd6, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        lo_we = 1'b1;
        wd    = 32'd1234;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        check("mtlo_busy_ignored", lo, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        check("after_flush_lo", lo, 32'd42);
        check("after_flush_hi", hi, 32'd0);

        @(negedge clk);
        lo_we = 1'b1;
        wd    = 32'd1234;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        check("mtlo_idle", lo, 32'd1234);
        @(negedge clk);
        hi_we = 1'b1;
        wd    = 32'h0000_5555;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        check("mthi_idle", hi, 32'h0000_5555);

        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b01;
        a     = 32'd9;
        b     = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_beats_start", busy, 0);

        @(negedge clk);
        start = 1'b1;
        hi_we = 1'b1;
        wd    = 32'h0000_AAAA;
        op    = 2'b01;
        a     = 32'd2;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        check("start_mthi_hi", hi, 32'h0000_AAAA);
        check("start_mthi_busy", busy, 1);
        wait_done(lat, bc);
        check("start_mthi_lo", lo, 32'd6);
        check("start_mthi_hi2", hi, 32'd0);

        launch(2'b01, 32'd6, 32'd7);
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        @(negedge clk);
        reset_n = 1'b1;

        launch(2'b11, 32'd100, 32'd7);
        wait_done(lat, bc);
        check("divu_100_7_lat", lat, 33);
        check("divu_100_7_lo", lo, 32'd14);
        check("divu_100_7_hi", hi, 32'd2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
